tube_scan_ctrl: RTL and testbench

Time-multiplexed scan controller for the 8-digit seven-segment tube block. It sits on the MMIO write bus beside the LED and switch registers. The CPU writes display content into shadow registers and requests a commit. The controller latches the shadow content at the next frame boundary, then scans digits with an inter-digit blanking gap so the tubes neither tear nor ghost.

---
 rtl/io_pkg.sv | 26 ++
 rtl/seg_decoder.sv | 31 +++
 rtl/tube_scan_ctrl.sv | 158 +++++++++++++++
 tb/tb_tube_scan_ctrl.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/io_pkg.sv
// Shared MMIO definitions for the display/IO blocks: tube register map,
// CTRL bit positions, the register bundle type and the scan FSM states.
package io_pkg;

    localparam logic [1:0] TUBE_ADDR_DATA     = 2'd0;
    localparam logic [1:0] TUBE_ADDR_DIGIT_EN = 2'd1;
    localparam logic [1:0] TUBE_ADDR_DP       = 2'd2;
    localparam logic [1:0] TUBE_ADDR_CTRL     = 2'd3;

    localparam int unsigned TUBE_CTRL_COMMIT_BIT = 0;
    localparam int unsigned TUBE_CTRL_RAW_BIT    = 1;

    // One copy of the display content; used for both shadow and active sets
    typedef struct packed {
        logic [31:0] data;
        logic [7:0]  digit_en;
        logic [7:0]  dp;
        logic        raw;
    } tube_regs_t;

    typedef enum logic {
        SCAN_BLANK = 1'b0,
        SCAN_SHOW  = 1'b1
    } scan_state_t;

endpackage

// File: rtl/seg_decoder.sv
// Combinational hex nibble to seven-segment decoder.
// Output is active-high {g,f,e,d,c,b,a}.
module seg_decoder (
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    // Glyph lookup for 0-9, A, b, C, d, E, F
    always_comb begin
        seg = '0;
        case (nibble)
            4'h0: seg = 7'h3F;
            4'h1: seg = 7'h06;
            4'h2: seg = 7'h5B;
            4'h3: seg = 7'h4F;
            4'h4: seg = 7'h66;
            4'h5: seg = 7'h6D;
            4'h6: seg = 7'h7D;
            4'h7: seg = 7'h07;
            4'h8: seg = 7'h7F;
            4'h9: seg = 7'h6F;
            4'hA: seg = 7'h77;
            4'hB: seg = 7'h7C;
            4'hC: seg = 7'h39;
            4'hD: seg = 7'h5E;
            4'hE: seg = 7'h79;
            4'hF: seg = 7'h71;
        endcase
    end

endmodule

// File: rtl/tube_scan_ctrl.sv
// Eight-digit seven-segment scan controller with shadow/active registers,
// frame-boundary commit and per-slot blanking gap.
// Optional macro TUBE_LEADING_ZERO_BLANK_EN: suppress leading zeros in hex mode.
module tube_scan_ctrl
    import io_pkg::*;
#(
    parameter int unsigned CLK_HZ       = 100_000_000,
    parameter int unsigned SCAN_HZ      = 1000,
    parameter int unsigned BLANK_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_valid,
    output logic        wr_ready,
    input  logic [1:0]  wr_addr,
    input  logic [31:0] wr_data,
    output logic        busy,
    output logic        frame_done,
    output logic [7:0]  tube_en,
    output logic [7:0]  tube_seg
);

    localparam int unsigned DIV   = CLK_HZ / SCAN_HZ;
    localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);

    generate
        if (DIV < BLANK_CYCLES + 2) begin : g_div_check
            $error("tube_scan_ctrl: CLK_HZ/SCAN_HZ must be at least BLANK_CYCLES+2");
        end
    endgenerate

    scan_state_t      state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [2:0]       dig, dig_nxt;
    logic             frame_cond;
    tube_regs_t       shadow, active;
    logic [4:0]       nib_lsb, raw_lsb;
    logic [3:0]       nib;
    logic [6:0]       hex;
    logic             lz_blank;
    logic [7:0]       en_d, seg_d;

    assign frame_cond = (dig == 3'd7) && (cnt == CNT_LAST);
    assign wr_ready   = ~busy;
    assign nib_lsb    = {dig, 2'b00};
    assign raw_lsb    = {dig[1:0], 3'b000};
    assign nib        = active.data[nib_lsb +: 4];

    seg_decoder u_seg_decoder (
        .nibble (nib),
        .seg    (hex)
    );

`ifdef TUBE_LEADING_ZERO_BLANK_EN
    logic [2:0] msd;

    // Highest enabled digit holding a non-zero nibble (0 when all are zero)
    always_comb begin
        msd = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            if (active.digit_en[i] && (active.data[4*i +: 4] != 4'd0)) begin
                msd = 3'(i);
            end
        end
    end

    assign lz_blank = (dig > msd) && !active.dp[dig];
`else
    assign lz_blank = 1'b0;
`endif

    // Scan state register: slot counter, digit index and BLANK/SHOW phase
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= SCAN_BLANK;
            cnt   <= '0;
            dig   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            dig   <= dig_nxt;
        end
    end

    // Next-state: counter wraps each slot, digit advances on wrap
    always_comb begin
        cnt_nxt = cnt + CNT_W'(1);
        dig_nxt = dig;
        if (cnt == CNT_LAST) begin
            cnt_nxt = '0;
            dig_nxt = dig + 3'd1;
        end
        state_nxt = (32'(cnt_nxt) < BLANK_CYCLES) ? SCAN_BLANK : SCAN_SHOW;
    end

    // Output decode for the current slot; registered below
    always_comb begin
        en_d  = '1;
        seg_d = '1;
        if (state == SCAN_SHOW) begin
            if (active.raw) begin
                if (!dig[2] && active.digit_en[dig]) begin
                    en_d  = ~(8'd1 << dig);
                    seg_d = ~active.data[raw_lsb +: 8];
                end
            end else if (active.digit_en[dig]) begin
                en_d = ~(8'd1 << dig);
                if (!lz_blank) begin
                    seg_d = ~{active.dp[dig], hex};
                end
            end
        end
    end

    // Registered pins and frame pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tube_en    <= '1;
            tube_seg   <= '1;
            frame_done <= 1'b0;
        end else begin
            tube_en    <= en_d;
            tube_seg   <= seg_d;
            frame_done <= frame_cond;
        end
    end

    // MMIO writes into shadow; commit copies shadow to active at frame end.
    // A commit accepted on the boundary cycle sees busy=0 there, so it waits
    // for the following boundary.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow <= '0;
            active <= '0;
            busy   <= 1'b0;
        end else begin
            if (frame_cond && busy) begin
                active <= shadow;
                busy   <= 1'b0;
            end
            if (wr_valid && !busy) begin
                case (wr_addr)
                    TUBE_ADDR_DATA:     shadow.data     <= wr_data;
                    TUBE_ADDR_DIGIT_EN: shadow.digit_en <= wr_data[7:0];
                    TUBE_ADDR_DP:       shadow.dp       <= wr_data[7:0];
                    TUBE_ADDR_CTRL: begin
                        shadow.raw <= wr_data[TUBE_CTRL_RAW_BIT];
                        if (wr_data[TUBE_CTRL_COMMIT_BIT]) begin
                            busy <= 1'b1;
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_tube_scan_ctrl.sv
// Self-checking bench for tube_scan_ctrl with DIV=10, BLANK_CYCLES=2.
// A captured frame holds pins for slot index 10*digit + cnt.
module tb_tube_scan_ctrl;
    import io_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_valid;
    logic        wr_ready;
    logic [1:0]  wr_addr;
    logic [31:0] wr_data;
    logic        busy;
    logic        frame_done;
    logic [7:0]  tube_en;
    logic [7:0]  tube_seg;

    int errors = 0;
    int checks = 0;

    logic [7:0] cap_en  [80];
    logic [7:0] cap_seg [80];

    typedef struct {
        logic [31:0] data;
        logic [7:0]  en;
        logic [7:0]  dp;
        logic        raw;
        int unsigned dig;
        logic [7:0]  exp_en;
        logic [7:0]  exp_seg;
    } vec_t;

    vec_t vecs[$];

`ifdef TUBE_LEADING_ZERO_BLANK_EN
    localparam logic [7:0] LZ_SEG = 8'hFF;
`else
    localparam logic [7:0] LZ_SEG = 8'hC0;
`endif

    always #5 clk = ~clk;

    tube_scan_ctrl #(
        .CLK_HZ       (1000),
        .SCAN_HZ      (100),
        .BLANK_CYCLES (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .busy       (busy),
        .frame_done (frame_done),
        .tube_en    (tube_en),
        .tube_seg   (tube_seg)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s: got timeout expected event", name);
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        int n;
        @(negedge clk);
        wr_valid = 1'b1;
        wr_addr  = a;
        wr_data  = d;
        n = 0;
        while (!wr_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!wr_ready) begin
            timeout("wr_ready");
            wr_valid = 1'b0;
        end else begin
            @(posedge clk);
            #1;
            wr_valid = 1'b0;
        end
    endtask

    task automatic wait_frame();
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            if (frame_done) return;
        end
        timeout("frame_done");
    endtask

    task automatic wait_commit();
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            if (frame_done && !busy) return;
        end
        timeout("commit");
    endtask

    // Called on a frame_done cycle; records the 80 slots of the next frame
    task automatic capture();
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            cap_en[i]  = tube_en;
            cap_seg[i] = tube_seg;
        end
    endtask

    task automatic commit_cfg(input logic [31:0] d, input logic [7:0] en,
                              input logic [7:0] dp, input logic raw);
        wr(TUBE_ADDR_DATA, d);
        wr(TUBE_ADDR_DIGIT_EN, {24'd0, en});
        wr(TUBE_ADDR_DP, {24'd0, dp});
        wr(TUBE_ADDR_CTRL, {30'd0, raw, 1'b1});
        wait_commit();
    endtask

    initial begin
        int n;
        int good;
        int k;
        logic [7:0] s5;
        logic fd_first;
        vec_t p;

        vecs.push_back('{32'h8765_4321, 8'hFF, 8'h00, 1'b0, 0, 8'hFE, 8'hF9});
        vecs.push_back('{32'h8765_4321, 8'hFF, 8'h00, 1'b0, 7, 8'h7F, 8'h80});
        vecs.push_back('{32'h8765_4321, 8'hFF, 8'h00, 1'b0, 3, 8'hF7, 8'h99});
        vecs.push_back('{32'h8765_4321, 8'hFF, 8'h00, 1'b0, 5, 8'hDF, 8'h82});
        vecs.push_back('{32'h0000_0000, 8'h05, 8'h04, 1'b0, 2, 8'hFB, 8'h40});
        vecs.push_back('{32'h0000_0000, 8'h05, 8'h04, 1'b0, 0, 8'hFE, 8'hC0});
        vecs.push_back('{32'h0000_0000, 8'h05, 8'h04, 1'b0, 1, 8'hFF, 8'hFF});
        vecs.push_back('{32'hFEDC_BA98, 8'hFF, 8'h80, 1'b0, 7, 8'h7F, 8'h0E});
        vecs.push_back('{32'hFEDC_BA98, 8'hFF, 8'h80, 1'b0, 1, 8'hFD, 8'h90});
        vecs.push_back('{32'hFEDC_BA98, 8'hFF, 8'h80, 1'b0, 6, 8'hBF, 8'h86});
        vecs.push_back('{32'hFEDC_BA98, 8'hFF, 8'h80, 1'b0, 4, 8'hEF, 8'hC6});
        vecs.push_back('{32'hFEDC_BA98, 8'hFF, 8'h80, 1'b0, 5, 8'hDF, 8'hA1});
        vecs.push_back('{32'h1234_5678, 8'hFF, 8'h00, 1'b1, 0, 8'hFE, 8'h87});
        vecs.push_back('{32'h1234_5678, 8'hFF, 8'h00, 1'b1, 2, 8'hFB, 8'hCB});
        vecs.push_back('{32'h1234_5678, 8'hFF, 8'h00, 1'b1, 5, 8'hFF, 8'hFF});
        vecs.push_back('{32'h0000_00A0, 8'hFF, 8'h00, 1'b0, 1, 8'hFD, 8'h88});
        vecs.push_back('{32'h0000_00A0, 8'hFF, 8'h00, 1'b0, 0, 8'hFE, 8'hC0});
        vecs.push_back('{32'h0000_00A0, 8'hFF, 8'h00, 1'b0, 4, 8'hEF, LZ_SEG});

        // Reset state
        rst      = 1'b1;
        wr_valid = 1'b0;
        wr_addr  = '0;
        wr_data  = '0;
        #12;
        check("rst_tube_en", tube_en, 8'hFF);
        check("rst_tube_seg", tube_seg, 8'hFF);
        check("rst_busy", busy, 1'b0);
        check("rst_wr_ready", wr_ready, 1'b1);
        check("rst_frame_done", frame_done, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        // Commit flow: busy holds off writes until the boundary
        wr(TUBE_ADDR_DATA, 32'h8765_4321);
        wr(TUBE_ADDR_DIGIT_EN, 32'h0000_00FF);
        wr(TUBE_ADDR_CTRL, 32'h0000_0001);
        @(negedge clk);
        check("flow_busy_set", busy, 1'b1);
        check("flow_ready_low", wr_ready, 1'b0);
        wait_commit();
        check("flow_ready_back", wr_ready, 1'b1);
        capture();
        check("flow_d0_en", cap_en[5], 8'hFE);
        check("flow_d0_seg", cap_seg[5], 8'hF9);
        check("flow_d7_en", cap_en[75], 8'h7F);
        check("flow_d7_seg", cap_seg[75], 8'h80);

        // Blanking: 2 dark cycles then 8 cycles of one digit per slot
        for (int s = 0; s < 8; s++) begin
            good = 0;
            for (int c = 0; c < 10; c++) begin
                if (c < 2 && cap_en[10*s+c] == 8'hFF) good++;
                if (c >= 2 && cap_en[10*s+c] == ~(8'd1 << s)) good++;
            end
            check($sformatf("blank_slot%0d", s), good, 10);
        end

        // frame_done period and width
        check("fd_at_frame_end", frame_done, 1'b1);
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (n == 1) check("fd_width", frame_done, 1'b0);
        end while (!frame_done && n < 200);
        check("fd_period", n, 80);

        // Shadow write without commit must not reach the display
        wr(TUBE_ADDR_DATA, 32'h0000_0000);
        wait_frame();
        capture();
        check("nocommit_d0_seg", cap_seg[5], 8'hF9);

        // Vector table
        p = '{32'hFFFF_FFFF, 8'h00, 8'h00, 1'b0, 0, 8'h00, 8'h00};
        foreach (vecs[i]) begin
            if (vecs[i].data != p.data || vecs[i].en != p.en ||
                vecs[i].dp != p.dp || vecs[i].raw != p.raw) begin
                commit_cfg(vecs[i].data, vecs[i].en, vecs[i].dp, vecs[i].raw);
                capture();
                p = vecs[i];
            end
            check($sformatf("vec%0d_en", i), cap_en[10*vecs[i].dig+5], vecs[i].exp_en);
            check($sformatf("vec%0d_seg", i), cap_seg[10*vecs[i].dig+5], vecs[i].exp_seg);
        end

        // Commit collision: CTRL accepted on the frame boundary edge
        commit_cfg(32'h1111_1111, 8'hFF, 8'h00, 1'b0);
        wr(TUBE_ADDR_DATA, 32'h2222_2222);
        repeat (77) @(negedge clk);
        wr(TUBE_ADDR_CTRL, 32'h0000_0001);
        k = 0;
        s5 = 8'h00;
        fd_first = 1'b0;
        for (int m = 0; m < 300; m++) begin
            @(negedge clk);
            if (!busy) break;
            if (k == 0) fd_first = frame_done;
            if (k == 6) s5 = tube_seg;
            k++;
        end
        check("coll_on_boundary", fd_first, 1'b1);
        check("coll_busy_cycles", k, 80);
        check("coll_old_data", s5, 8'hF9);
        check("coll_commit_fd", frame_done, 1'b1);
        capture();
        check("coll_new_en", cap_en[5], 8'hFE);
        check("coll_new_seg", cap_seg[5], 8'hA4);

        // Mid-frame reset with a commit pending
        wr(TUBE_ADDR_CTRL, 32'h0000_0001);
        n = 0;
        while (tube_en == 8'hFF && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("mid_lit_before_rst", tube_en, 8'hFE);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_en", tube_en, 8'hFF);
        check("mid_rst_seg", tube_seg, 8'hFF);
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_ready", wr_ready, 1'b1);
        @(negedge clk);
        rst = 1'b0;
        wr(TUBE_ADDR_CTRL, 32'h0000_0001);
        wait_commit();
        capture();
        check("mid_cleared_d0_en", cap_en[5], 8'hFF);
        check("mid_cleared_d7_en", cap_en[75], 8'hFF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
